// File: rtl/conv_mac_array_seq.sv
// Self-sequenced conv MAC: loads TAPS weights, then streams NUM_OUT*TAPS features
// into per-output saturating accumulators and presents the clamped map on a valid/ready port.

module conv_mac_lane #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] prod,
    output logic [OUT_W-1:0]  res
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // One spare bit catches the carry so the sum sticks at all-ones instead of wrapping.
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end

    generate
        if (OUT_W < ACC_W) begin : g_clamp
            assign res = (|acc[ACC_W-1:OUT_W]) ? '1 : acc[OUT_W-1:0];
        end else begin : g_pass
            assign res = acc[OUT_W-1:0];
        end
    endgenerate
endmodule

module conv_mac_array_seq #(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 4,
    parameter int NUM_OUT = 4,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     keep_w,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_OUT*OUT_W-1:0] out_data,
    output logic                     busy
);
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OIDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_F, DONE} state_t;

    state_t                         state;
    logic [TAPS-1:0][DATA_W-1:0]    weight;
    logic [TAP_W-1:0]               tap;
    logic [OIDX_W-1:0]              out_idx;
    logic                           beat, last_tap, last_out, clr;
    logic [PROD_W-1:0]              prod;
    logic [NUM_OUT-1:0][OUT_W-1:0]  res;

    assign beat     = in_valid & in_ready;
    assign last_tap = (tap == TAP_W'(TAPS - 1));
    assign last_out = (out_idx == OIDX_W'(NUM_OUT - 1));
    assign clr      = (state == IDLE) & start;
    assign prod     = PROD_W'(in_data) * PROD_W'(weight[tap]);
    assign out_data = res;

    // Feature order is output-major, so only the lane addressed by out_idx accumulates.
    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
            conv_mac_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .PROD_W(PROD_W)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .en   ((state == LOAD_F) & beat & (out_idx == OIDX_W'(k))),
                .prod (prod),
                .res  (res[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tap       <= '0;
            out_idx   <= '0;
            weight    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tap      <= '0;
                    out_idx  <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    state    <= keep_w ? LOAD_F : LOAD_W;
                end
                LOAD_W: if (beat) begin
                    weight[tap] <= in_data;
                    if (last_tap) begin
                        tap   <= '0;
                        state <= LOAD_F;
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                LOAD_F: if (beat) begin
                    if (last_tap) begin
                        tap <= '0;
                        if (last_out) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_idx <= out_idx + OIDX_W'(1);
                        end
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_array_seq.sv
// Scoreboard bench for conv_mac_array_seq: jobs push expected maps, a monitor
// pops and compares on every accepted output and checks hold stability.

module tb_conv_mac_array_seq;
    localparam int DATA_W  = 8;
    localparam int TAPS    = 4;
    localparam int NUM_OUT = 4;
    localparam int ACC_W   = 16;
    localparam int OUT_W   = 8;
    localparam int OD_W    = NUM_OUT * OUT_W;
    localparam int NF      = NUM_OUT * TAPS;

    typedef logic [DATA_W-1:0] wvec_t [TAPS];
    typedef logic [DATA_W-1:0] fvec_t [NF];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, keep_w = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid, busy;
    logic [OD_W-1:0]   out_data;

    conv_mac_array_seq #(.DATA_W(DATA_W), .TAPS(TAPS), .NUM_OUT(NUM_OUT),
                         .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_w(keep_w),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int              n_vec = 0, n_err = 0, rdy_cnt = 0;
    logic [OD_W-1:0] exp_q [$];
    logic [OD_W-1:0] held;
    logic            holding = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [OD_W-1:0] pack4(input int c11, input int c12, input int c21, input int c22);
        return {8'(c22), 8'(c21), 8'(c12), 8'(c11)};
    endfunction

    // Monitor: compare on every accepted result, and require out_data to hold while stalled.
    always @(negedge clk) begin
        if (in_ready) rdy_cnt++;
        if (!rst) holding = 1'b0;
        else if (out_valid) begin
            if (holding) check("out_stable", 64'(out_data), 64'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                holding = 1'b0;
            end else begin
                holding = 1'b1;
                held    = out_data;
            end
        end else holding = 1'b0;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int gap);
        logic r;
        r = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) break;
        end
        if (!r) begin n_vec++; n_err++; $display("FAIL send_timeout: got in_ready 0 expected 1"); end
        in_valid = 1'b0;
    endtask

    // glitch raises start during one mid-feature beat, which must be ignored
    task automatic feed_job(input logic kw, input wvec_t w, input fvec_t f,
                            input int gap_max, input logic glitch, input int nfeat);
        start = 1'b1; keep_w = kw;
        tick();
        start = 1'b0; keep_w = 1'b0;
        if (!kw) for (int i = 0; i < TAPS; i++) send(w[i], $urandom_range(0, gap_max));
        for (int i = 0; i < nfeat; i++) begin
            if (glitch && i == 5) start = 1'b1;
            send(f[i], $urandom_range(0, gap_max));
            start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        logic b;
        b = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); b = busy;
            if (!b) break;
        end
        if (b) begin n_vec++; n_err++; $display("FAIL idle_timeout: got busy 1 expected 0"); end
        tick();
    endtask

    task automatic wait_valid();
        logic v;
        v = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); v = out_valid;
            if (v) break;
        end
        if (!v) begin n_vec++; n_err++; $display("FAIL valid_timeout: got out_valid 0 expected 1"); end
    endtask

    wvec_t w1, wsat;
    fvec_t f1, fsat, fone;
    logic [OD_W-1:0] exp_t1;
    int vcnt;

    initial begin
        for (int i = 0; i < TAPS; i++) begin w1[i] = DATA_W'(i + 1); wsat[i] = 8'd255; end
        for (int i = 0; i < NF; i++) begin f1[i] = DATA_W'(i + 1); fsat[i] = 8'd255; fone[i] = 8'd1; end
        exp_t1 = pack4(30, 70, 110, 150);

        #2 rst = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        tick();

        // T1 basic job, 4 weight + 16 feature ready cycles
        exp_q.push_back(exp_t1);
        rdy_cnt = 0;
        feed_job(1'b0, w1, f1, 0, 1'b0, NF);
        wait_idle();
        check("t1_ready_cycles", 64'(rdy_cnt), 64'd20);

        // T3 reuse weights: no weight phase
        exp_q.push_back(pack4(10, 10, 10, 10));
        rdy_cnt = 0;
        feed_job(1'b1, w1, fone, 0, 1'b0, NF);
        wait_idle();
        check("t3_ready_cycles", 64'(rdy_cnt), 64'd16);

        // T2 saturation
        exp_q.push_back(pack4(255, 255, 255, 255));
        feed_job(1'b0, wsat, fsat, 0, 1'b0, NF);
        wait_idle();

        // T4 input bubbles and 20 stalled output cycles
        out_ready = 1'b0;
        exp_q.push_back(exp_t1);
        feed_job(1'b0, w1, f1, 2, 1'b0, NF);
        wait_valid();
        vcnt = 0;
        repeat (20) begin @(negedge clk); if (out_valid) vcnt++; end
        check("t4_valid_held", 64'(vcnt), 64'd20);
        check("t4_data_held", 64'(out_data), 64'(exp_t1));
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle();

        // T5 reset mid-feature load
        feed_job(1'b0, w1, f1, 0, 1'b0, 7);
        rst = 1'b0;
        #1;
        check("t5_in_ready", 64'(in_ready), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_data", 64'(out_data), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        // weights cleared by reset, so a keep_w job yields zeros
        exp_q.push_back(pack4(0, 0, 0, 0));
        feed_job(1'b1, w1, fone, 0, 1'b0, NF);
        wait_idle();
        exp_q.push_back(exp_t1);
        feed_job(1'b0, w1, f1, 0, 1'b0, NF);
        wait_idle();

        // T6 start during LOAD_F, during DONE and on the DONE->IDLE handoff
        out_ready = 1'b0;
        exp_q.push_back(exp_t1);
        feed_job(1'b0, w1, f1, 0, 1'b1, NF);
        wait_valid();
        @(posedge clk); #1 start = 1'b1;
        repeat (3) tick();
        check("t6_done_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t6_busy_after", 64'(busy), 64'd0);
        @(negedge clk);
        check("t6_in_ready_after", 64'(in_ready), 64'd0);
        tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
